// File: rtl/sync_fifo_pkg.sv
// Shared defaults, flag payload type and the pointer-to-flag helper for sync_fifo.
package sync_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 16;
  localparam int unsigned PTR_WIDTH_DEF  = 4;

  typedef struct packed {
    logic full;
    logic empty;
  } flags_t;

  // Pointers carry one wrap bit above the address; callers zero-extend to 32 bits.
  // Full means the pointers differ in the wrap bit only.
  function automatic flags_t ptr_flags(input logic [31:0] wptr,
                                       input logic [31:0] rptr,
                                       input int unsigned ptr_width);
    flags_t f;
    f.empty = (wptr == rptr);
    f.full  = ((wptr ^ rptr) == (32'd1 << ptr_width));
    return f;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read data.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH = PTR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is not reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact registered full/empty flags and registered dout.
// Define SYNC_FIFO_ERR_EN to add registered overflow/underflow pulse outputs.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned PTR_WIDTH  = PTR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
`ifdef SYNC_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  full
);

  localparam int unsigned PW = PTR_WIDTH + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_next;
  logic [PW-1:0] rptr_next;
  logic          wr_accept;
  logic          rd_accept;
  flags_t        flags_next;

  // Requests are qualified by the registered flags, so rejected requests touch nothing.
  assign wr_accept  = wr_en && !full;
  assign rd_accept  = rd_en && !empty;
  assign wptr_next  = wr_accept ? wptr + PW'(1) : wptr;
  assign rptr_next  = rd_accept ? rptr + PW'(1) : rptr;
  assign flags_next = ptr_flags(32'(wptr_next), 32'(rptr_next), PTR_WIDTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wptr  <= wptr_next;
      rptr  <= rptr_next;
      empty <= flags_next.empty;
      full  <= flags_next.full;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(PTR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .wr_en(wr_accept),
    .waddr(wptr[PTR_WIDTH-1:0]),
    .wdata(din),
    .rd_en(rd_accept),
    .raddr(rptr[PTR_WIDTH-1:0]),
    .rdata(dout)
  );

`ifdef SYNC_FIFO_ERR_EN
  // One-cycle pulses flagging requests the FIFO had to reject.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: reset, fill, overflow, drain,
// underflow, concurrent traffic across the pointer wrap, and mid-stream reset.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty;
  logic       full;
`ifdef SYNC_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int n_vec;
  int n_miscompare;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (16),
    .PTR_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .din      (din),
    .dout     (dout),
    .empty    (empty),
`ifdef SYNC_FIFO_ERR_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec        = 0;
    n_miscompare = 0;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;

    #20;
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    #2 rst = 1'b1;
    step();
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_dout", 32'(dout), 32'h00);

    // Fill with 0x10..0x1F
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din   = 8'(8'h10 + i);
      step();
      chk("fill_empty", 32'(empty), 32'd0);
      chk("fill_full", 32'(full), (i == 15) ? 32'd1 : 32'd0);
    end

    // Write while full must be dropped
    din = 8'hAA;
    step();
    wr_en = 1'b0;
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_empty", 32'(empty), 32'd0);
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf_pulse", 32'(overflow), 32'd1);
    step();
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
`endif

    // Drain: expect 0x10..0x1F in order, never 0xAA
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_dout", 32'(dout), 32'(8'h10 + i));
      chk("drain_full", 32'(full), 32'd0);
      chk("drain_empty", 32'(empty), (i == 15) ? 32'd1 : 32'd0);
    end

    // Read while empty must be ignored
    step();
    rd_en = 1'b0;
    chk("udf_dout", 32'(dout), 32'h1F);
    chk("udf_empty", 32'(empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    chk("udf_pulse", 32'(underflow), 32'd1);
`endif
    step();
    chk("idle_hold_dout", 32'(dout), 32'h1F);
`ifdef SYNC_FIFO_ERR_EN
    chk("udf_pulse_end", 32'(underflow), 32'd0);
`endif

    // Preload 0x01..0x08
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      din   = 8'(i + 1);
      step();
    end
    chk("preload_empty", 32'(empty), 32'd0);
    chk("preload_full", 32'(full), 32'd0);
    chk("preload_dout_hold", 32'(dout), 32'h1F);

    // 20 cycles of simultaneous write/read; the pointers wrap during this run
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = 8'(8'h20 + i);
      step();
      chk("conc_dout", 32'(dout), (i < 8) ? 32'(i + 1) : 32'(8'h20 + i - 8));
      chk("conc_empty", 32'(empty), 32'd0);
      chk("conc_full", 32'(full), 32'd0);
    end

    // Asynchronous reset mid-stream
    #3 rst = 1'b0;
    #1;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_full", 32'(full), 32'd0);
    chk("midrst_dout", 32'(dout), 32'h00);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #12 rst = 1'b1;
    step();
    chk("after_rst_empty", 32'(empty), 32'd1);

    // Single write/read after reset restarts cleanly
    wr_en = 1'b1;
    din   = 8'h5C;
    step();
    wr_en = 1'b0;
    chk("restart_empty", 32'(empty), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("restart_dout", 32'(dout), 32'h5C);
    chk("restart_empty2", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock first-in first-out buffer of DEPTH words, each DATA_WIDTH bits wide. It decouples a producer and a consumer in the same clock domain. Writes and reads are gated by wr_en and rd_en. The full and empty flags are exact and registered, and read data is registered on dout.

Parameters:
DATA_WIDTH, 8, width of din and dout.
DEPTH, 16, number of storage words; must equal 2**PTR_WIDTH.
PTR_WIDTH, 4, address width of the storage array.

Ports:
clk    input   1           rising-edge clock; the only clock.
rst    input   1           asynchronous, active-low reset.
wr_en  input   1           write request.
rd_en  input   1           read request.
din    input   DATA_WIDTH  write data.
dout   output  DATA_WIDTH  registered read data.
empty  output  1           high when the FIFO holds 0 words.
full   output  1           high when the FIFO holds DEPTH words.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - write and read pointers = 0
  - dout = 0, empty = 1, full = 0
  - storage contents are don't-care
  - normal operation resumes on the first rising edge after rst returns to 1.
- Pointers are PTR_WIDTH+1 bits wide. The low PTR_WIDTH bits address the array; the MSB is a wrap bit. Both pointers increment modulo 2**(PTR_WIDTH+1).
- Write is accepted iff wr_en=1 and full=0, sampled before the edge. On that edge mem[wptr] <= din and wptr increments.
- Read is accepted iff rd_en=1 and empty=0, sampled before the edge. On that edge dout <= mem[rptr] and rptr increments.
- Read latency: data is valid on dout right after the accepting edge. dout holds its last value whenever no read is accepted.
- Write when full: silently dropped. Pointers, data and flags are unchanged.
- Read when empty: silently ignored. dout holds its value and pointers are unchanged.
- Simultaneous requests:
  - Both accepted (0 < occupancy < DEPTH): both pointers advance and occupancy is unchanged.
  - When empty: only the write is accepted.
  - When full: only the read is accepted.
- Flags derived from the pointers:
  - empty = (wptr == rptr).
  - full = MSBs differ and low PTR_WIDTH bits are equal.
  - Both flags update on the same edge as the pointer change (no extra latency).
- Wrap-around: after any number of complete fill/drain cycles, ordering and flags stay correct.
- Data ordering is strictly FIFO. No data is corrupted by a rejected request.

Optional Feature:
Macro SYNC_FIFO_ERR_EN.
- Defined: adds two outputs, overflow and underflow, each 1 bit, registered, reset to 0.
  - overflow pulses high for one cycle after an edge where wr_en=1 and full=1.
  - underflow pulses high for one cycle after an edge where rd_en=1 and empty=1.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - default constants DATA_WIDTH_DEF=8, DEPTH_DEF=16, PTR_WIDTH_DEF=4
  - a function computing full/empty from two pointers.
- One sub-module, sync_fifo_mem: a simple dual-port register array with a synchronous write port and a registered read port. The top level holds the pointers, flags and optional error logic.

Test Plan:
- Reset: assert rst=0 for 20 ns, then release -> dout=0x00, empty=1, full=0.
- Fill: 16 consecutive writes of 0x10..0x1F -> empty deasserts after the 1st edge; full=1 after the 16th edge.
- Overflow: with full=1, write 0xAA -> full stays 1 and 0xAA is never read back. With SYNC_FIFO_ERR_EN, overflow pulses once.
- Drain: 16 consecutive reads -> dout shows 0x10..0x1F in order, one per edge; full clears after the 1st read; empty=1 after the 16th.
- Underflow: with empty=1, rd_en=1 -> dout holds 0x1F and empty stays 1. With SYNC_FIFO_ERR_EN, underflow pulses once.
- Concurrency, wrap and reset:
  - Preload 0x01..0x08, then 20 cycles of simultaneous write 0x20.. and read -> order preserved across the pointer wrap, flags steady.
  - Assert rst mid-stream -> empty=1, full=0 and dout=0 immediately.
